// File: rtl/router_out_fifo.sv
// Per-destination output FIFO of the 1x3 router. Header-flagged entries drive a packet counter that blanks data_out between packets.
// Optional timeout flush is built when ROUTER_FIFO_SOFT_RESET_EN is defined.
module router_out_fifo #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full,
  output logic             empty,
  output logic             soft_reset
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH:0]   mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [6:0]       pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH:0]   rd_entry;
  logic             wr_acc, rd_acc, flush;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign valid_out = !empty;
  assign data_out  = data_out_q;

  assign rd_entry = mem[rd_ptr_q[AW-1:0]];
  assign wr_acc   = write_enb && !full && !flush;
  assign rd_acc   = read_enb && !empty;

`ifdef ROUTER_FIFO_SOFT_RESET_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          soft_reset_q;
  logic          stalled;

  assign stalled    = valid_out && !read_enb;
  assign flush      = stalled && (to_cnt_q == TW'(TIMEOUT - 1));
  assign soft_reset = soft_reset_q;

  always_comb begin
    to_cnt_d = '0;
    if (stalled && !flush) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      to_cnt_q     <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      to_cnt_q     <= to_cnt_d;
      soft_reset_q <= flush;
    end
  end
`else
  assign flush      = 1'b0;
  assign soft_reset = 1'b0;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = rd_entry[WIDTH-1:0];
      // Header byte carries payload length in [7:2]; +1 covers the parity byte.
      if (rd_entry[WIDTH]) pkt_cnt_d = {1'b0, rd_entry[7:2]} + 7'd1;
      else if (pkt_cnt_q != '0) pkt_cnt_d = pkt_cnt_q - 7'd1;
    end else if (pkt_cnt_q == '0) begin
      data_out_d = '0;
    end
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define contents.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
  end

endmodule

// File: tb/tb_router_out_fifo.sv
// Directed bench for router_out_fifo: reset, packet blanking, full/concurrent boundaries, wrap-around, timeout flush.
module tb_router_out_fifo;
  logic       clock = 1'b0;
  logic       resetn;
  logic       write_enb, lfd_state, read_enb;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out, full, empty, soft_reset;
  int         checks = 0;
  int         failures = 0;

  router_out_fifo #(.DEPTH(16), .WIDTH(8), .TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn), .write_enb(write_enb), .lfd_state(lfd_state),
    .data_in(data_in), .read_enb(read_enb), .data_out(data_out),
    .valid_out(valid_out), .full(full), .empty(empty), .soft_reset(soft_reset)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic hdr);
    write_enb = 1'b1; data_in = d; lfd_state = hdr;
    step();
    write_enb = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #2 resetn = 1'b1;
    step();
  endtask

  logic [7:0] pkt [5];

  initial begin
    pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h3C;
    resetn = 1'b0; write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b0; data_in = '0;
    #12;
    chk("rst_empty", empty, 1); chk("rst_valid", valid_out, 0); chk("rst_full", full, 0);
    chk("rst_dout", data_out, 0); chk("rst_soft", soft_reset, 0);
    resetn = 1'b1;
    step();

    // Async reset mid-packet: header read so data_out is non-zero beforehand
    for (int i = 0; i < 5; i++) wr(pkt[i], i == 0);
    read_enb = 1'b1; step(); read_enb = 1'b0;
    chk("pre_rst_dout", data_out, 8'h0C);
    #2 resetn = 1'b0;
    #1;
    chk("async_empty", empty, 1); chk("async_valid", valid_out, 0); chk("async_dout", data_out, 0);
    #1 resetn = 1'b1;
    step();

    // Single packet with header length 3
    for (int i = 0; i < 5; i++) begin
      wr(pkt[i], i == 0);
      if (i == 0) chk("pkt_valid_rise", valid_out, 1);
    end
    read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("pkt_dout%0d", i), data_out, pkt[i]);
      chk($sformatf("pkt_valid%0d", i), valid_out, (i == 4) ? 0 : 1);
    end
    step();
    chk("pkt_blank", data_out, 0);
    read_enb = 1'b0;

    // Fill past full; 17th write dropped
    for (int i = 1; i <= 17; i++) begin
      wr(8'(i), 1'b0);
      if (i == 15) chk("full_at15", full, 0);
      if (i == 16) chk("full_at16", full, 1);
    end
    chk("full_after17", full, 1);
    write_enb = 1'b1; data_in = 8'hAA; read_enb = 1'b1;
    step();
    write_enb = 1'b0; read_enb = 1'b0;
    chk("conc_full_dout", data_out, 8'h01);
    chk("conc_full_flag", full, 0);
    wr(8'hBB, 1'b0);
    chk("refill_full", full, 1);
    read_enb = 1'b1;
    for (int i = 2; i <= 17; i++) begin
      step();
      chk($sformatf("drain%0d", i), data_out, (i == 17) ? 8'hBB : 8'(i));
    end
    read_enb = 1'b0;
    chk("drain_empty", empty, 1);

    // Concurrent access at occupancy 8
    for (int i = 0; i < 8; i++) wr(8'h21 + 8'(i), 1'b0);
    write_enb = 1'b1; data_in = 8'h29; read_enb = 1'b1;
    step();
    write_enb = 1'b0;
    chk("conc8_dout", data_out, 8'h21);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("occ8_dout%0d", i), data_out, 8'h22 + 8'(i));
      chk($sformatf("occ8_empty%0d", i), empty, (i == 7) ? 1 : 0);
    end
    read_enb = 1'b0;

    // Wrap-around: 40 simultaneous write/read pairs at occupancy 3
    for (int i = 0; i < 3; i++) wr(8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      write_enb = 1'b1; data_in = 8'h43 + 8'(i); read_enb = 1'b1;
      step();
      chk($sformatf("wrap_dout%0d", i), data_out, 8'h40 + 8'(i));
      chk($sformatf("wrap_flags%0d", i), {full, empty}, 2'b00);
    end
    write_enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wrap_tail%0d", i), data_out, 8'h68 + 8'(i));
    end
    read_enb = 1'b0;
    chk("wrap_empty", empty, 1);
    for (int i = 0; i < 16; i++) begin
      wr(8'h80 + 8'(i), 1'b0);
      chk($sformatf("wrap_full%0d", i), full, (i == 15) ? 1 : 0);
    end
    read_enb = 1'b1; step(); read_enb = 1'b0;
    chk("wrap_full_head", data_out, 8'h80);
    do_reset();

`ifdef ROUTER_FIFO_SOFT_RESET_EN
    // Flush 30 cycles after valid_out rises
    for (int k = 0; k < 3; k++) wr(8'h50 + 8'(k), 1'b0);
    for (int k = 3; k < 30; k++) begin
      step();
      chk($sformatf("to_quiet%0d", k), soft_reset, 0);
    end
    step();
    chk("to_pulse", soft_reset, 1);
    chk("to_empty", empty, 1);
    step();
    chk("to_pulse_end", soft_reset, 0);
    do_reset();

    // Read pulse at cycle 20 restarts the count; flush lands at cycle 50
    for (int k = 0; k < 3; k++) wr(8'h60 + 8'(k), 1'b0);
    for (int k = 3; k < 20; k++) begin
      step();
      chk($sformatf("to2_quiet%0d", k), soft_reset, 0);
    end
    read_enb = 1'b1; step(); read_enb = 1'b0;
    for (int k = 21; k < 50; k++) begin
      step();
      chk($sformatf("to2_hold%0d", k), soft_reset, 0);
    end
    step();
    chk("to2_pulse", soft_reset, 1);
    chk("to2_empty", empty, 1);
`else
    for (int k = 0; k < 3; k++) wr(8'h50 + 8'(k), 1'b0);
    for (int k = 0; k < 40; k++) begin
      step();
      chk($sformatf("nto_soft%0d", k), soft_reset, 0);
    end
    chk("nto_valid", valid_out, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/router_out_fifo.md
# router_out_fifo

Per-destination output buffer of the 1x3 router. It sits directly upstream of the destination interface and holds bytes written by the router's register stage. It presents those bytes on `data_out`/`valid_out`, and the destination drains them with `read_enb`. It tracks packet boundaries through a header marker, so it can blank `data_out` between packets. Optionally, it flushes itself when the destination stops reading.

## Interface
- `DEPTH`, 16, number of entries; power of two, minimum 4.
- `WIDTH`, 8, data byte width.
- `TIMEOUT`, 30, cycles without a read (while `valid_out` is high) before a soft reset fires.

- `clock` in 1: single clock; everything is sampled on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `write_enb` in 1: write request from the register stage.
- `lfd_state` in 1: marks the byte being written as a packet header.
- `data_in` in WIDTH: write data.
- `read_enb` in 1: read request from the destination.
- `data_out` out WIDTH: registered read data.
- `valid_out` out 1: FIFO holds at least one entry; equals `!empty`.
- `full` out 1: occupancy equals DEPTH.
- `empty` out 1: occupancy equals 0.
- `soft_reset` out 1: one-cycle pulse on timeout flush.

## Operation
- **Storage:** DEPTH entries of WIDTH+1 bits. Bit WIDTH holds the header flag, captured from `lfd_state`.
- **Pointers:** write and read pointers are `$clog2(DEPTH)+1` bits wide. The MSB is a wrap bit.
  - `full` when the low bits are equal and the MSBs differ.
  - `empty` when the pointers are identical.
- **Write:** accepted when `write_enb && !full`. The entry stores {lfd_state, data_in} and the write pointer increments. A write while `full` is dropped with no state change.
- **Read:** accepted when `read_enb && !empty`. The entry is registered into `data_out` and the read pointer increments.
- **Packet counter:** 7 bits wide.
  - Read of a header-flagged entry: load counter = `data[7:2] + 1` (payload length plus parity byte).
  - Read of a non-header entry: decrement, saturating at 0.
- **Blanking:** when no read is accepted this cycle and the counter is 0, `data_out` is driven to 0. Otherwise `data_out` holds its last value.
- **Simultaneous read and write:**
  - Both are accepted when neither `full` nor `empty` blocks them; occupancy is unchanged.
  - When `empty`, only the write takes effect.
  - When `full`, only the read takes effect. The write is dropped, because `full` is evaluated on registered pointers.
- **Wrap-around:** pointers wrap naturally modulo 2*DEPTH. No special handling is needed.

## Timing
- **Reset values:** `data_out`=0, `valid_out`=0, `full`=0, `empty`=1, `soft_reset`=0, pointers=0, counter=0, timeout counter=0. Reset applies immediately on `resetn` falling and is released synchronously by the register clocking.
- **Read latency:** `read_enb` sampled high at edge N puts the byte on `data_out` after edge N. The destination samples it at edge N+1.
- **Flag latency:**
  - `valid_out`, `full` and `empty` are decoded combinationally from registered pointers.
  - They update in the same cycle as the pointer change, i.e. after the edge that accepts the access.
- **Write-to-visible latency:** a write at edge N raises `valid_out` after edge N.
- **Storage contents:** entries are not cleared by reset. Only the pointers are cleared.

## Configuration
- **Macro:** `ROUTER_FIFO_SOFT_RESET_EN`.
- **When defined:**
  - A timeout counter increments each cycle that `valid_out && !read_enb`. It clears on any cycle where `read_enb` is high or `valid_out` is low.
  - When the count reaches TIMEOUT-1, the next edge pulses `soft_reset` for one cycle. On that same edge it clears the pointers, packet counter, timeout counter and `data_out`.
  - A flush coincident with a write drops the write.
- **When undefined:** `soft_reset` is tied to 0 and no timeout logic is synthesised.

## Test plan
- **Reset:** assert `resetn`=0 mid-packet after 5 writes → `empty`=1, `valid_out`=0 and `data_out`=0 immediately, with no clock needed.
- **Single packet:**
  - Stimulus: write header 0x0C (`lfd_state`=1, length 3), then 0x11, 0x22, 0x33, then parity 0x3C; then hold `read_enb`=1.
  - Required response: `data_out` sequence is 0x0C, 0x11, 0x22, 0x33, 0x3C, then 0x00.
  - `valid_out` falls after the 5th read.
- **Full:** write 17 bytes 0x01..0x11 with no reads → `full`=1 after the 16th. Then read all 16 → 0x01..0x10; the 17th byte was dropped.
- **Concurrent access at boundaries:**
  - At occupancy 16: `write_enb`=1 and `read_enb`=1 → read accepted, write dropped, occupancy becomes 15.
  - At occupancy 8: both asserted → occupancy stays 8.
- **Wrap-around:** 40 interleaved write/read pairs → data order is preserved, and `full`/`empty` are correct across pointer MSB toggles.
- **Timeout flush** (`ROUTER_FIFO_SOFT_RESET_EN` defined): write 3 bytes and hold `read_enb`=0 → `soft_reset` pulses once 30 cycles after `valid_out` rose; then `empty`=1.
  - With a `read_enb` pulse at cycle 20, no flush occurs before cycle 50.
